cfi_ctrl_wb_cmd_master: RTL and testbench
=========================================

Name: cfi_ctrl_wb_cmd_master

Overview:
- Hardware Wishbone classic master that drives the `cfi_ctrl` slave (`cfi_engine="ENABLED"`). It is the initiator end of the same bus.
- Accepts one high-level flash command at a time: read, 32-bit program, unlock+erase block, clear status, read device ident, or CFI query.
- Expands each command into the controller's Wishbone access sequence, including status polling, and returns one response.
- Used by boot loaders and the update engine in place of the software master.

Parameters:
- POLL_LIMIT, 65535: maximum status reads per wait-for-ready before timeout.
- BASE_UNLOCK, 32'h0400_0000: unlock window offset.
- BASE_ERASE, 32'h0800_0000: erase window offset.
- STATUS_ADR, 32'h0c00_0004: status read address; bit 7 = ready.
- CLRSTAT_ADR, 32'h0c00_0000: clear-status write address.
- BASE_IDENT, 32'h0e00_0000: device-ident window.
- BASE_QUERY, 32'h0e01_0000: CFI query window.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_op_i  in  3  0 READ32, 1 PROG32, 2 UNLOCK_ERASE, 3 CLR_STATUS, 4 IDENT16, 5 QUERY16; 6/7 reserved.
- cmd_adr_i  in  32  byte address (ops 0-2), word index (ops 4-5).
- cmd_dat_i  in  32  program data (PROG32).
- rsp_valid_o  out  1  single-cycle response strobe.
- rsp_dat_o  out  32  read data, or last status byte zero-extended.
- rsp_err_o  out  1  poll timeout, reserved op, or flash error bit.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  byte selects.
- wbm_we_o  out  1  write enable.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o=1. The state machine returns to IDLE with no handshake. Reset mid-transaction drops stb/cyc on the next edge; the partial flash operation is abandoned.
- Handshake: command accepted when cmd_valid_i & cmd_ready_o; op, address and data are registered. cmd_ready_o=0 from the next cycle until rsp_valid_o pulses. The earliest new accept is the cycle after rsp_valid_o.
- Bus cycle rules:
  - stb=cyc=1 with adr/dat/sel/we stable until the cycle where wbm_ack_i=1 is sampled.
  - Then one GAP cycle with stb=cyc=0 before any further access.
  - wbm_ack_i is ignored when stb=0.
  - No bus timeout on ack.
- 16-bit write encoding: adr={a[31:2],2'b00}; dat={d16,d16}; sel = a[1] ? 4'h3 : 4'hc.
- 16-bit read encoding: same adr/sel. Result is a[1] ? dat_i[15:0] : dat_i[31:16], zero-extended.
- States: IDLE, ACCESS, GAP, POLL, RESP. A step counter (3 bits) indexes the op's access list.
- WAIT_RDY procedure:
  - Repeated 32-bit reads (sel 4'hf) of STATUS_ADR until dat_i[7]=1.
  - A counter, cleared at each WAIT_RDY entry, counts reads. Timeout when POLL_LIMIT reads have seen bit7=0.
  - On timeout: abort remaining steps, rsp_err_o=1, rsp_dat_o = last status.
- Op sequences:
  - READ32: one 32-bit read of a, sel f → rsp_dat_o.
  - PROG32:
    1. write16(a, d[31:16])
    2. WAIT_RDY
    3. write16(a+2, d[15:0])
    4. WAIT_RDY
    - rsp_dat_o = final status.
  - UNLOCK_ERASE:
    1. write32(BASE_UNLOCK+a, 0)
    2. write32(BASE_ERASE+a, 0)
    3. WAIT_RDY
  - CLR_STATUS: write32(CLRSTAT_ADR, 32'h2).
  - IDENT16 / QUERY16: read16(BASE+(idx<<1)).
  - Reserved op: no bus activity; rsp_err_o=1 the cycle after accept.
- Error on ready status: rsp_err_o = status[5]|status[4]|status[3]|status[1].
  - A PROG32 first half with error still performs the second half.
  - The error flags are ORed into the response.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- rsp_valid_o is high exactly one cycle, in RESP. rsp_dat_o/rsp_err_o hold until the next accept.

Decomposition:
- Shared package cfi_ctrl_pkg holds:
  - op code constants;
  - window base addresses;
  - status bit indices (READY=7, ERASE_ERR=5, PROG_ERR=4, VPP_ERR=3, LOCK_ERR=1).
- One sub-module, cfi_wbm_access: single Wishbone classic access engine including the GAP cycle, with a start/done interface.

Test Plan:
- PROG32 a=0, d=32'hdeadbeef, then READ32 a=0 → bus writes 16'hdead with sel c and 16'hbeef with sel 3. Each write is followed by ≥1 status read at 32'h0c00_0004. READ32 rsp_dat_o=32'hdeadbeef, rsp_err_o=0.
- UNLOCK_ERASE a=32'h20000 → writes at 32'h0402_0000 then 32'h0802_0000, then polls until bit7. rsp_err_o=0, rsp_dat_o=32'h80.
- IDENT16 idx=1 and QUERY16 idx=16'h10 → adr 32'h0e00_0000 with sel 3 and adr 32'h0e01_0020 with sel c. QUERY16 rsp_dat_o=32'h0051 ('Q').
- Slave model holding status 8'h00, POLL_LIMIT=8 → exactly 8 status reads, rsp_err_o=1, rsp_dat_o=0.
- Ack held high on every cycle, plus reset asserted mid-PROG32 → one GAP cycle (stb=0) between every access. After reset: stb=cyc=0, cmd_ready_o=1 on the next edge.
- Reserved op 7 → no stb asserted, rsp_valid_o on cycle accept+1 with rsp_err_o=1.

Source files
------------

// File: rtl/cfi_ctrl_pkg.sv
// cfi_ctrl_pkg: op codes, window addresses, status bits and access descriptors for the cfi_ctrl command master
package cfi_ctrl_pkg;

    localparam logic [2:0] OP_READ32   = 3'd0;
    localparam logic [2:0] OP_PROG32   = 3'd1;
    localparam logic [2:0] OP_ERASE    = 3'd2;
    localparam logic [2:0] OP_CLRSTAT  = 3'd3;
    localparam logic [2:0] OP_IDENT16  = 3'd4;
    localparam logic [2:0] OP_QUERY16  = 3'd5;

    localparam logic [31:0] WIN_UNLOCK  = 32'h0400_0000;
    localparam logic [31:0] WIN_ERASE   = 32'h0800_0000;
    localparam logic [31:0] ADR_STATUS  = 32'h0c00_0004;
    localparam logic [31:0] ADR_CLRSTAT = 32'h0c00_0000;
    localparam logic [31:0] WIN_IDENT   = 32'h0e00_0000;
    localparam logic [31:0] WIN_QUERY   = 32'h0e01_0000;

    localparam int ST_READY     = 7;
    localparam int ST_ERASE_ERR = 5;
    localparam int ST_PROG_ERR  = 4;
    localparam int ST_VPP_ERR   = 3;
    localparam int ST_LOCK_ERR  = 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_GAP, S_POLL, S_RESP} state_t;
    typedef enum logic [1:0] {A_IDLE, A_ACCESS, A_GAP} acc_state_t;
    typedef enum logic [1:0] {K_DONE, K_ACC, K_WAIT} kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } acc_t;

    localparam acc_t NO_ACC = '0;

    // Halfword access: word-aligned address, data replicated, lane chosen by a[1]
    function automatic acc_t acc16(input logic [31:0] a, input logic [15:0] d, input logic we);
        return '{kind: K_ACC, adr: {a[31:2], 2'b00}, dat: {d, d}, sel: a[1] ? 4'h3 : 4'hc, we: we};
    endfunction

    function automatic acc_t acc32(input logic [31:0] a, input logic [31:0] d, input logic we);
        return '{kind: K_ACC, adr: a, dat: d, sel: 4'hf, we: we};
    endfunction

    function automatic logic st_err(input logic [7:0] s);
        return s[ST_ERASE_ERR] | s[ST_PROG_ERR] | s[ST_VPP_ERR] | s[ST_LOCK_ERR];
    endfunction

endpackage

// File: rtl/cfi_ctrl_wb_cmd_master_if.sv
// cfi_ctrl_wb_cmd_master_if: Wishbone classic bus between the command master and the cfi_ctrl slave
// adr/dat_w/sel/we/stb/cyc driven by master; dat_r/ack driven by slave.
interface cfi_ctrl_wb_cmd_master_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    modport master (output adr, dat_w, sel, we, stb, cyc, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/cfi_wbm_access.sv
// cfi_wbm_access: one Wishbone classic access per start, followed by a mandatory idle GAP cycle
// Ports: wb_clk_i/wb_rst_i clock and sync reset; start_i with adr_i/dat_i/sel_i/we_i launch an
// access (accepted when not mid-access); done_o pulses in the ack cycle with rdat_o valid; wb bus.
module cfi_wbm_access
    import cfi_ctrl_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    output logic        done_o,
    output logic [31:0] rdat_o,
    cfi_ctrl_wb_cmd_master_if.master wb
);

    acc_state_t  st_q, st_d;
    logic [31:0] adr_q, dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    // The GAP state can take a new start directly, so back-to-back accesses get exactly one idle cycle
    always_comb begin
        st_d = st_q == A_ACCESS ? (wb.ack ? A_GAP : A_ACCESS) : (start_i ? A_ACCESS : A_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st_q  <= A_IDLE;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (start_i && st_q != A_ACCESS) begin
                adr_q <= adr_i;
                dat_q <= dat_i;
                sel_q <= sel_i;
                we_q  <= we_i;
            end
        end
    end

    assign wb.stb   = st_q == A_ACCESS;
    assign wb.cyc   = st_q == A_ACCESS;
    assign wb.adr   = adr_q;
    assign wb.dat_w = dat_q;
    assign wb.sel   = sel_q;
    assign wb.we    = we_q;
    assign done_o   = st_q == A_ACCESS && wb.ack;
    assign rdat_o   = wb.dat_r;

endmodule

// File: rtl/cfi_ctrl_wb_cmd_master.sv
// cfi_ctrl_wb_cmd_master: expands high-level flash commands into cfi_ctrl Wishbone access sequences
// Ports: wb_clk_i/wb_rst_i clock and sync reset; cmd_* command handshake (ready only in IDLE);
// rsp_* one-cycle response strobe with held data/error; wbm Wishbone master bus.
module cfi_ctrl_wb_cmd_master
    import cfi_ctrl_pkg::*;
#(
    parameter int unsigned POLL_LIMIT  = 65535,
    parameter logic [31:0] BASE_UNLOCK = WIN_UNLOCK,
    parameter logic [31:0] BASE_ERASE  = WIN_ERASE,
    parameter logic [31:0] STATUS_ADR  = ADR_STATUS,
    parameter logic [31:0] CLRSTAT_ADR = ADR_CLRSTAT,
    parameter logic [31:0] BASE_IDENT  = WIN_IDENT,
    parameter logic [31:0] BASE_QUERY  = WIN_QUERY
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    cfi_ctrl_wb_cmd_master_if.master wbm
);

    state_t      st_q, st_d;
    logic [2:0]  op_q, step_q;
    logic [31:0] adr_q, dat_q, poll_q, res_q, rdat, id_adr;
    logic        err_q, start, done, timeout;
    acc_t        acc, wait_acc;

    assign wait_acc = '{kind: K_WAIT, adr: STATUS_ADR, dat: 32'h0, sel: 4'hf, we: 1'b0};
    assign id_adr   = (op_q == OP_QUERY16 ? BASE_QUERY : BASE_IDENT) + {adr_q[30:0], 1'b0};
    assign timeout  = poll_q + 32'd1 >= POLL_LIMIT;

    // Access list of the current op, indexed by step; K_DONE marks the end of the list
    always_comb begin
        acc = NO_ACC;
        case (op_q)
            OP_READ32:  acc = step_q == 3'd0 ? acc32(adr_q, 32'h0, 1'b0) : NO_ACC;
            OP_PROG32:  acc = step_q == 3'd0 ? acc16(adr_q, dat_q[31:16], 1'b1)
                            : step_q == 3'd2 ? acc16(adr_q + 32'd2, dat_q[15:0], 1'b1)
                            : (step_q == 3'd1 || step_q == 3'd3) ? wait_acc : NO_ACC;
            OP_ERASE:   acc = step_q == 3'd0 ? acc32(BASE_UNLOCK + adr_q, 32'h0, 1'b1)
                            : step_q == 3'd1 ? acc32(BASE_ERASE + adr_q, 32'h0, 1'b1)
                            : step_q == 3'd2 ? wait_acc : NO_ACC;
            OP_CLRSTAT: acc = step_q == 3'd0 ? acc32(CLRSTAT_ADR, 32'h2, 1'b1) : NO_ACC;
            OP_IDENT16,
            OP_QUERY16: acc = step_q == 3'd0 ? acc16(id_adr, 16'h0, 1'b0) : NO_ACC;
            default:    acc = NO_ACC;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        start = 1'b0;
        case (st_q)
            S_IDLE:   st_d = cmd_valid_i ? (cmd_op_i > OP_QUERY16 ? S_RESP : S_GAP) : S_IDLE;
            S_GAP: begin
                start = acc.kind != K_DONE;
                st_d  = acc.kind == K_DONE ? S_RESP : acc.kind == K_WAIT ? S_POLL : S_ACCESS;
            end
            S_ACCESS: st_d = done ? S_GAP : S_ACCESS;
            S_POLL:   st_d = !done ? S_POLL : (!rdat[ST_READY] && timeout) ? S_RESP : S_GAP;
            default:  st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st_q   <= S_IDLE;
            op_q   <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            step_q <= '0;
            poll_q <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == S_IDLE && cmd_valid_i) begin
                op_q   <= cmd_op_i;
                adr_q  <= cmd_adr_i;
                dat_q  <= cmd_dat_i;
                step_q <= '0;
                poll_q <= '0;
                res_q  <= '0;
                err_q  <= cmd_op_i > OP_QUERY16;
            end
            if (st_q == S_ACCESS && done) begin
                step_q <= step_q + 3'd1;
                poll_q <= '0;
                if (op_q == OP_READ32)
                    res_q <= rdat;
                else if (op_q == OP_IDENT16 || op_q == OP_QUERY16)
                    res_q <= {16'h0, id_adr[1] ? rdat[15:0] : rdat[31:16]};
            end
            // Every status read is kept so a timeout reports the last status seen
            if (st_q == S_POLL && done) begin
                res_q <= {24'h0, rdat[7:0]};
                if (rdat[ST_READY]) begin
                    step_q <= step_q + 3'd1;
                    poll_q <= '0;
                    err_q  <= err_q | st_err(rdat[7:0]);
                end else begin
                    poll_q <= poll_q + 32'd1;
                    if (timeout) err_q <= 1'b1;
                end
            end
        end
    end

    cfi_wbm_access u_access (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start_i  (start),
        .adr_i    (acc.adr),
        .dat_i    (acc.dat),
        .sel_i    (acc.sel),
        .we_i     (acc.we),
        .done_o   (done),
        .rdat_o   (rdat),
        .wb       (wbm)
    );

    assign cmd_ready_o = st_q == S_IDLE;
    assign rsp_valid_o = st_q == S_RESP;
    assign rsp_dat_o   = res_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_cfi_ctrl_wb_cmd_master.sv
// tb_cfi_ctrl_wb_cmd_master: directed self-checking bench with a small cfi_ctrl slave model
module tb_cfi_ctrl_wb_cmd_master;
    import cfi_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cfi_ctrl_wb_cmd_master_if wbm ();

    cfi_ctrl_wb_cmd_master #(.POLL_LIMIT(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm         (wbm)
    );

    // Slave model: one wait state (or ack every cycle), 16-word flash array, status busy for 2 polls after a write
    typedef struct packed {logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;} rec_t;
    rec_t        log_q[$];
    int          gaps[$];
    logic        ack_all = 1'b0, stuck = 1'b0, ack_q = 1'b0;
    logic [7:0]  flag_inj = 8'h00;
    int          busy = 0;
    logic [31:0] mem [0:15];

    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    assign wbm.ack   = ack_all | ack_q;
    assign wbm.dat_r = wbm.adr == 32'h0c00_0004 ? {24'h0, (stuck || busy > 0) ? 8'h00 : (8'h80 | flag_inj)}
                     : wbm.adr == 32'h0e00_0000 ? 32'h0089_00aa
                     : wbm.adr == 32'h0e01_0020 ? 32'h0051_0052
                     : wbm.adr < 32'h0400_0000  ? mem[wbm.adr[5:2]] : 32'h0;

    always @(posedge clk) begin
        ack_q <= !ack_all && wbm.stb && !ack_q;
        if (wbm.stb && wbm.ack) begin
            if (wbm.we && wbm.adr < 32'h0c00_0000) busy <= 2;
            if (wbm.we && wbm.adr < 32'h0400_0000)
                for (int b = 0; b < 4; b++)
                    if (wbm.sel[b]) mem[wbm.adr[5:2]][8*b +: 8] <= wbm.dat_w[8*b +: 8];
            if (!wbm.we && wbm.adr == 32'h0c00_0004 && busy > 0) busy <= busy - 1;
        end
    end

    // Bus monitor: access log, idle-gap lengths within a command, stb count, request stability
    int          stb_cycles = 0, low_cnt = 0, stab_viol = 0;
    bit          seen_acc = 0;
    logic        stb_prev = 1'b0, ack_prev = 1'b0;
    rec_t        req_prev;

    always @(negedge clk) begin
        if (wbm.stb) begin
            stb_cycles++;
            if (!stb_prev && seen_acc) gaps.push_back(low_cnt);
            if (stb_prev && !ack_prev && req_prev !== rec_t'{wbm.adr, wbm.dat_w, wbm.sel, wbm.we}) stab_viol++;
            low_cnt  = 0;
            seen_acc = 1;
        end else low_cnt++;
        if (wbm.stb && wbm.ack) log_q.push_back('{wbm.adr, wbm.dat_w, wbm.sel, wbm.we});
        if (rsp_valid || rst) seen_acc = 0;
        stb_prev = wbm.stb;
        ack_prev = wbm.ack;
        req_prev = '{wbm.adr, wbm.dat_w, wbm.sel, wbm.we};
    end

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d, output int lat);
        log_q.delete();
        stb_cycles = 0;
        @(negedge clk);
        cmd_op = op; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cmd_ready_busy: got %b want 0", cmd_ready); end
        while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_timeout: op %0d no response after %0d cycles", op, lat); end
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse: rsp_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        n_chk++; if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin n_fail++; $display("FAIL rst_rsp: got %b %b %h want 0 0 0", rsp_valid, rsp_err, rsp_dat); end
        n_chk++; if ({wbm.stb, wbm.cyc, wbm.we, wbm.sel, wbm.adr, wbm.dat_w} !== 71'h0) begin n_fail++; $display("FAIL rst_bus: stb %b cyc %b adr %h want all 0", wbm.stb, wbm.cyc, wbm.adr); end
        rst = 1'b0;
    endtask

    task automatic test_prog_read;
        int lat, nst;
        do_cmd(OP_PROG32, 32'h0, 32'hdeadbeef, lat);
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b0, 32'h80}) begin n_fail++; $display("FAIL prog_rsp: got %b %h want 0 00000080", rsp_err, rsp_dat); end
        n_chk++; if (log_q.size() != 8) begin n_fail++; $display("FAIL prog_len: got %0d want 8", log_q.size()); end
        n_chk++; if (log_q[0] !== rec_t'{32'h0, 32'hdeaddead, 4'hc, 1'b1}) begin n_fail++; $display("FAIL prog_hi: got %h want %h", log_q[0], rec_t'{32'h0, 32'hdeaddead, 4'hc, 1'b1}); end
        n_chk++; if (log_q[4] !== rec_t'{32'h0, 32'hbeefbeef, 4'h3, 1'b1}) begin n_fail++; $display("FAIL prog_lo: got %h want %h", log_q[4], rec_t'{32'h0, 32'hbeefbeef, 4'h3, 1'b1}); end
        nst = 0;
        foreach (log_q[i]) if (i != 0 && i != 4 && log_q[i].adr == 32'h0c00_0004 && log_q[i].sel == 4'hf && !log_q[i].we) nst++;
        n_chk++; if (nst != 6) begin n_fail++; $display("FAIL prog_polls: got %0d want 6", nst); end
        do_cmd(OP_READ32, 32'h0, 32'h0, lat);
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b0, 32'hdeadbeef}) begin n_fail++; $display("FAIL read32: got %b %h want 0 deadbeef", rsp_err, rsp_dat); end
        n_chk++; if (log_q.size() != 1 || log_q[0] !== rec_t'{32'h0, 32'h0, 4'hf, 1'b0}) begin n_fail++; $display("FAIL read32_bus: got %0d %h", log_q.size(), log_q[0]); end
    endtask

    task automatic test_erase;
        int lat;
        do_cmd(OP_ERASE, 32'h0002_0000, 32'h0, lat);
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b0, 32'h80}) begin n_fail++; $display("FAIL erase_rsp: got %b %h want 0 00000080", rsp_err, rsp_dat); end
        n_chk++; if (log_q[0] !== rec_t'{32'h0402_0000, 32'h0, 4'hf, 1'b1}) begin n_fail++; $display("FAIL erase_unlock: got %h", log_q[0]); end
        n_chk++; if (log_q[1] !== rec_t'{32'h0802_0000, 32'h0, 4'hf, 1'b1}) begin n_fail++; $display("FAIL erase_erase: got %h", log_q[1]); end
        n_chk++; if (log_q.size() != 5 || log_q[4].adr !== 32'h0c00_0004) begin n_fail++; $display("FAIL erase_polls: got %0d accesses want 5", log_q.size()); end
    endtask

    task automatic test_ident_query;
        int lat;
        do_cmd(OP_IDENT16, 32'h1, 32'h0, lat);
        n_chk++; if (log_q[0].adr !== 32'h0e00_0000 || log_q[0].sel !== 4'h3) begin n_fail++; $display("FAIL ident_bus: got %h %h want 0e000000 3", log_q[0].adr, log_q[0].sel); end
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b0, 32'h00aa}) begin n_fail++; $display("FAIL ident_rsp: got %b %h want 0 000000aa", rsp_err, rsp_dat); end
        do_cmd(OP_QUERY16, 32'h10, 32'h0, lat);
        n_chk++; if (log_q[0].adr !== 32'h0e01_0020 || log_q[0].sel !== 4'hc) begin n_fail++; $display("FAIL query_bus: got %h %h want 0e010020 c", log_q[0].adr, log_q[0].sel); end
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b0, 32'h0051}) begin n_fail++; $display("FAIL query_rsp: got %b %h want 0 00000051", rsp_err, rsp_dat); end
    endtask

    task automatic test_clr_status;
        int lat;
        do_cmd(OP_CLRSTAT, 32'h0, 32'h0, lat);
        n_chk++; if (log_q.size() != 1 || log_q[0] !== rec_t'{32'h0c00_0000, 32'h2, 4'hf, 1'b1}) begin n_fail++; $display("FAIL clr_bus: got %0d %h", log_q.size(), log_q[0]); end
        n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_timeout;
        int lat;
        stuck = 1'b1;
        do_cmd(OP_PROG32, 32'h10, 32'h1111_2222, lat);
        stuck = 1'b0;
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL timeout_rsp: got %b %h want 1 00000000", rsp_err, rsp_dat); end
        n_chk++; if (log_q.size() != 9 || log_q[8].adr !== 32'h0c00_0004) begin n_fail++; $display("FAIL timeout_polls: got %0d accesses want 9", log_q.size()); end
    endtask

    task automatic test_prog_err;
        int lat, nwr;
        flag_inj = 8'h10;
        do_cmd(OP_PROG32, 32'h14, 32'h0000_ffff, lat);
        flag_inj = 8'h00;
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].we) nwr++;
        n_chk++; if (nwr != 2) begin n_fail++; $display("FAIL progerr_writes: got %0d want 2", nwr); end
        n_chk++; if ({rsp_err, rsp_dat} !== {1'b1, 32'h90}) begin n_fail++; $display("FAIL progerr_rsp: got %b %h want 1 00000090", rsp_err, rsp_dat); end
    endtask

    task automatic test_back_to_back;
        int lat, gmin, gmax;
        gaps.delete();
        ack_all = 1'b1;
        do_cmd(OP_PROG32, 32'h18, 32'hcafe_f00d, lat);
        gmin = 99; gmax = 0;
        foreach (gaps[i]) begin gmin = gaps[i] < gmin ? gaps[i] : gmin; gmax = gaps[i] > gmax ? gaps[i] : gmax; end
        n_chk++; if (gaps.size() != 7) begin n_fail++; $display("FAIL b2b_count: got %0d gaps want 7", gaps.size()); end
        n_chk++; if (gmin != 1 || gmax != 1) begin n_fail++; $display("FAIL b2b_gap: got min %0d max %0d want 1 1", gmin, gmax); end
        do_cmd(OP_READ32, 32'h18, 32'h0, lat);
        ack_all = 1'b0;
        n_chk++; if (rsp_dat !== 32'hcafef00d) begin n_fail++; $display("FAIL b2b_read: got %h want cafef00d", rsp_dat); end
        n_chk++; if (stab_viol != 0) begin n_fail++; $display("FAIL bus_stable: got %0d changes want 0", stab_viol); end
    endtask

    task automatic test_reset_mid;
        int k, lat;
        @(negedge clk);
        cmd_op = OP_PROG32; cmd_adr = 32'h20; cmd_dat = 32'h1234_5678; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (wbm.stb !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_chk++; if (wbm.stb !== 1'b1) begin n_fail++; $display("FAIL midrst_start: stb got %b want 1", wbm.stb); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({wbm.stb, wbm.cyc, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL midrst_state: stb/cyc/ready got %b want 001", {wbm.stb, wbm.cyc, cmd_ready}); end
        rst = 1'b0;
        do_cmd(OP_READ32, 32'h0, 32'h0, lat);
        n_chk++; if (rsp_dat !== 32'hdeadbeef) begin n_fail++; $display("FAIL midrst_read: got %h want deadbeef", rsp_dat); end
    endtask

    task automatic test_reserved;
        int lat;
        for (int op = 6; op < 8; op++) begin
            do_cmd(3'(op), 32'h0, 32'h0, lat);
            n_chk++; if (lat != 1) begin n_fail++; $display("FAIL rsv_latency: op %0d got %0d want 1", op, lat); end
            n_chk++; if ({rsp_err, rsp_dat} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rsv_rsp: op %0d got %b %h want 1 0", op, rsp_err, rsp_dat); end
            n_chk++; if (stb_cycles != 0) begin n_fail++; $display("FAIL rsv_bus: op %0d got %0d stb cycles want 0", op, stb_cycles); end
        end
    endtask

    initial begin
        test_reset();
        test_prog_read();
        test_erase();
        test_ident_query();
        test_clr_status();
        test_timeout();
        test_prog_err();
        test_back_to_back();
        test_reset_mid();
        test_reserved();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
